div_seq_param: RTL and testbench

DIV_SEQ_PARAM -- requirements
Module: div_seq_param

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_seq_param_cond_negate.sv | 17 +
 rtl/div_seq_param.sv | 170 +++++++++++++++++
 tb/tb_div_seq_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state type, default width, clog2 helper.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  function automatic int div_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_seq_param_cond_negate.sv
// cond_negate: combinational conditional two's-complement negation of a WIDTH-bit word.
module cond_negate
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  logic signed [WIDTH-1:0] w_val;

  assign w_val = i_val;
  assign o_val = i_neg ? -w_val : w_val;

endmodule

// File: rtl/div_seq_param.sv
// div_seq_param: restoring divider, one quotient bit per clock, signed or unsigned per operation.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor skips the iteration phase entirely.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH          = DIV_WIDTH_DEFAULT,
  parameter bit SIGNED_DEFAULT = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = div_clog2(WIDTH + 1);

  div_state_e         r_state;
  div_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed;
  logic               r_b_msb;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b_mag;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_start;
  logic               w_last_step;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_acc_step;
  logic               w_q_neg;
  logic               w_r_neg;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_start     = reset_n && ctrl_DIV && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_a_neg     = ctrl_signed & data_operandA[WIDTH-1];
  assign w_b_neg     = ctrl_signed & data_operandB[WIDTH-1];
  assign w_b_zero    = (data_operandB == '0);

  cond_negate #(.WIDTH(WIDTH)) u_mag_a (
    .i_val (data_operandA),
    .i_neg (w_a_neg),
    .o_val (w_a_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_mag_b (
    .i_val (data_operandB),
    .i_neg (w_b_neg),
    .o_val (w_b_mag)
  );

  // Trial subtraction on the shifted upper half, keeping the bit shifted out as a carry
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b_mag};

  always_comb begin
    if (!w_trial[WIDTH]) begin
      w_acc_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  assign w_q_neg = r_signed & (r_a[WIDTH-1] ^ r_b_msb);
  assign w_r_neg = r_signed & r_a[WIDTH-1];

  cond_negate #(.WIDTH(WIDTH)) u_fix_q (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (w_q_neg),
    .o_val (w_q_fix)
  );

  cond_negate #(.WIDTH(WIDTH)) u_fix_r (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (w_r_neg),
    .o_val (w_r_fix)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (ctrl_DIV) begin
`ifdef DIV_ZERO_FASTPATH_EN
          w_state_nxt = w_b_zero ? S_FIX : S_RUN;
`else
          w_state_nxt = S_RUN;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last_step) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state == S_RUN) || (r_state == S_FIX);
    data_resultRDY = (r_state == S_DONE);
  end

  // Control and result registers; results change only in FIX so they hold until the next completion
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_signed       <= SIGNED_DEFAULT;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt    <= '0;
        r_signed <= ctrl_signed;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_FIX) begin
        if (r_b_zero) begin
          data_result    <= '1;
          data_remainder <= r_a;
          data_exception <= 1'b1;
        end else begin
          data_result    <= w_q_fix;
          data_remainder <= w_r_fix;
          data_exception <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_start) begin
      r_a      <= data_operandA;
      r_b_mag  <= w_b_mag;
      r_b_msb  <= data_operandB[WIDTH-1];
      r_b_zero <= w_b_zero;
      r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_step;
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: directed corner cases plus random operands against an arithmetic model.
module tb_div_seq_param;

  localparam int W32 = 32;
  localparam int W8  = 8;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZERO_LAT32 = 2;
`else
  localparam int ZERO_LAT32 = W32 + 2;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        div32, sgn32, exc32, rdy32, busy32;
  logic [31:0] a32, b32, q32, r32;
  logic        div8, sgn8, exc8, rdy8, busy8;
  logic [7:0]  a8, b8, q8, r8;

  int n_vec = 0;
  int n_mis = 0;
  int edge_no = 0;

  always #5 clock = ~clock;
  always @(posedge clock) edge_no <= edge_no + 1;

  div_seq_param #(.WIDTH(W32), .SIGNED_DEFAULT(1'b1)) u_dut32 (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (div32),
    .ctrl_signed    (sgn32),
    .data_operandA  (a32),
    .data_operandB  (b32),
    .data_result    (q32),
    .data_remainder (r32),
    .data_exception (exc32),
    .data_resultRDY (rdy32),
    .busy           (busy32)
  );

  div_seq_param #(.WIDTH(W8), .SIGNED_DEFAULT(1'b0)) u_dut8 (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (div8),
    .ctrl_signed    (sgn8),
    .data_operandA  (a8),
    .data_operandB  (b8),
    .data_result    (q8),
    .data_remainder (r8),
    .data_exception (exc8),
    .data_resultRDY (rdy8),
    .busy           (busy8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Truncating division (quotient toward zero, remainder takes the dividend's sign)
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic s, output logic [63:0] q, output logic [63:0] r,
                                output logic e);
    logic [63:0] mask;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    e = (b == 64'd0);
    if (b == 64'd0) begin
      q = mask;
      r = a;
    end else if (s) begin
      sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
      sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = (a / b) & mask;
      r = (a % b) & mask;
    end
  endfunction

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] eq, input logic [31:0] er, input logic ee,
                      input int inject_at, input string tag);
    int k;
    a32 = a; b32 = b; sgn32 = s; div32 = 1'b1;
    tick();
    div32 = 1'b0;
    check({tag, " busy after start"}, 64'(busy32), 64'd1);
    k = 0;
    while (rdy32 !== 1'b1 && k < 200) begin
      if (k == inject_at) begin
        div32 = 1'b1; a32 = ~a; b32 = 32'd3; sgn32 = ~s;
      end
      tick();
      k++;
      if (k == inject_at + 1) div32 = 1'b0;
    end
    // The pulse is captured by the edge that closes the DONE cycle
    check({tag, " ready edge"}, 64'(k + 1), 64'((b == 32'd0) ? ZERO_LAT32 : W32 + 2));
    check({tag, " quotient"}, 64'(q32), 64'(eq));
    check({tag, " remainder"}, 64'(r32), 64'(er));
    check({tag, " exception"}, 64'(exc32), 64'(ee));
    check({tag, " busy in done"}, 64'(busy32), 64'd0);
    tick();
    check({tag, " ready single cycle"}, 64'(rdy32), 64'd0);
    check({tag, " quotient held"}, 64'(q32), 64'(eq));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input string tag, output int rdy_edge);
    logic [63:0] mq, mr;
    logic        me;
    int          k;
    model(W8, 64'(a), 64'(b), s, mq, mr, me);
    a8 = a; b8 = b; sgn8 = s; div8 = 1'b1;
    tick();
    div8 = 1'b0;
    check({tag, " busy after start"}, 64'(busy8), 64'd1);
    k = 0;
    while (rdy8 !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    rdy_edge = edge_no;
`ifdef DIV_ZERO_FASTPATH_EN
    check({tag, " ready edge"}, 64'(k + 1), 64'((b == 8'd0) ? 2 : W8 + 2));
`else
    check({tag, " ready edge"}, 64'(k + 1), 64'(W8 + 2));
`endif
    check({tag, " quotient"}, 64'(q8), mq & 64'hFF);
    check({tag, " remainder"}, 64'(r8), mr & 64'hFF);
    check({tag, " exception"}, 64'(exc8), 64'(me));
  endtask

  initial begin
    int e1, e2;
    int seen_rdy;
    reset_n = 1'b0;
    div32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    div8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    tick();
    tick();
    check("reset q32", 64'(q32), 64'd0);
    check("reset r32", 64'(r32), 64'd0);
    check("reset exc32", 64'(exc32), 64'd0);
    check("reset rdy32", 64'(rdy32), 64'd0);
    check("reset busy32", 64'(busy32), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset q8", 64'(q8), 64'd0);
    reset_n = 1'b1;
    tick();

    op32(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, -1, "u 100/7");
    op32(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, -1, "s -7/2");
    op32(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, -1, "s 7/-2");
    op32(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, -1, "u 5/0");
    op32(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, -1, "s -5/0");
    op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, -1, "s MIN/-1");
    op32(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, -1, "u max/1");
    op32(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, -1, "u 3/10");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      logic [63:0] mq, mr;
      logic        me;
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = -32'($urandom_range(1, 15));
        2:       rb = $urandom >> $urandom_range(0, 28);
        default: rb = $urandom;
      endcase
      model(W32, 64'(ra), 64'(rb), rs, mq, mr, me);
      op32(ra, rb, rs, mq[31:0], mr[31:0], me, -1, "rand32");
    end

    // A start request at edge 10 of a running operation must be dropped
    op32(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 9, "ignored start");

    a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0; div32 = 1'b1;
    tick();
    div32 = 1'b0;
    repeat (14) tick();
    reset_n = 1'b0; div32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
    tick();
    check("mid-op reset q", 64'(q32), 64'd0);
    check("mid-op reset r", 64'(r32), 64'd0);
    check("mid-op reset exc", 64'(exc32), 64'd0);
    check("mid-op reset busy", 64'(busy32), 64'd0);
    check("mid-op reset rdy", 64'(rdy32), 64'd0);
    tick();
    reset_n = 1'b1; div32 = 1'b0;
    seen_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rdy32 === 1'b1 || busy32 === 1'b1) seen_rdy++;
    end
    check("no activity after reset", 64'(seen_rdy), 64'd0);

    op8(8'd200, 8'd3, 1'b0, "w8 200/3", e1);
    op8(8'd9, 8'd3, 1'b0, "w8 9/3 back-to-back", e2);
    check("w8 ready spacing", 64'(e2 - e1), 64'd10);
    check("w8 second quotient", 64'(q8), 64'd3);
    tick();
    check("w8 idle after done", 64'(busy8), 64'd0);
    tick();
    op8(8'h80, 8'hFF, 1'b1, "w8 MIN/-1", e1);
    tick();
    op8(8'd77, 8'd0, 1'b0, "w8 77/0", e1);
    tick();
    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), "rand8", e1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
